// File: rtl/apb_requester.sv
// apb_requester: single-outstanding APB requester, IDLE -> SETUP -> ACCESS -> IDLE.
// Define APB_TMO_EN to add the wait-state timeout (counter + tmo_limit abort).
module apb_requester #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned TMO_W  = 8
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [TMO_W-1:0]  tmo_limit,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_tmo,
  output logic              busy,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e            state_q, state_d;
  logic              psel_d, penable_d, pwrite_d;
  logic [ADDR_W-1:0] paddr_d;
  logic [DATA_W-1:0] pwdata_d;
  logic              rsp_valid_d, rsp_err_d, rsp_tmo_d;
  logic [DATA_W-1:0] rsp_rdata_d;

`ifdef APB_TMO_EN
  logic [TMO_W-1:0]  cnt_q, cnt_d, cnt_inc;
`else
  logic              unused_tmo_limit;
  assign unused_tmo_limit = ^tmo_limit;
`endif

  // Status decodes straight off the state register
  assign cmd_ready = (state_q == IDLE);
  assign busy      = ~cmd_ready;

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    psel_d      = psel;
    penable_d   = penable;
    pwrite_d    = pwrite;
    paddr_d     = paddr;
    pwdata_d    = pwdata;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    rsp_tmo_d   = rsp_tmo;
`ifdef APB_TMO_EN
    cnt_d       = cnt_q;
    cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + TMO_W'(1);
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
`ifdef APB_TMO_EN
          cnt_d     = TMO_W'(0);
`endif
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite ? DATA_W'(0) : prdata;
          rsp_err_d   = pslverr;
          rsp_tmo_d   = 1'b0;
          state_d     = IDLE;
        end else begin
`ifdef APB_TMO_EN
          cnt_d = cnt_inc;
          // Abort on the wait cycle that brings the count up to the live limit
          if ((tmo_limit != TMO_W'(0)) && (cnt_inc >= tmo_limit)) begin
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = DATA_W'(0);
            rsp_err_d   = 1'b1;
            rsp_tmo_d   = 1'b1;
            state_d     = IDLE;
          end
`endif
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q   <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= ADDR_W'(0);
      pwdata    <= DATA_W'(0);
      rsp_valid <= 1'b0;
      rsp_rdata <= DATA_W'(0);
      rsp_err   <= 1'b0;
      rsp_tmo   <= 1'b0;
    end else begin
      state_q   <= state_d;
      psel      <= psel_d;
      penable   <= penable_d;
      pwrite    <= pwrite_d;
      paddr     <= paddr_d;
      pwdata    <= pwdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      rsp_tmo   <= rsp_tmo_d;
    end
  end

`ifdef APB_TMO_EN
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) cnt_q <= TMO_W'(0);
    else           cnt_q <= cnt_d;
  end
`endif

endmodule
